// File: rtl/min_max_scheduler_pkg.sv
// Shared constants, types and helpers for the min/max tree request scheduler.
package min_max_sched_pkg;

    localparam int DEF_DATA_W     = 3;
    localparam int DEF_NUM_INPUTS = 6;
    localparam int DEF_LATENCY    = 3;

    typedef logic [DEF_DATA_W-1:0] data_t;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/min_max_scheduler_if.sv
// Requester, tree and result-side signals of the min/max scheduler.
interface min_max_scheduler_if
    import min_max_sched_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int NUM_INPUTS = DEF_NUM_INPUTS,
    parameter int DATA_W     = DEF_DATA_W
);
    localparam int ID_W = idx_w(NUM_REQ);

    logic [NUM_REQ-1:0]                   req_valid;
    logic [NUM_REQ-1:0]                   req_ready;
    logic [NUM_REQ*NUM_INPUTS*DATA_W-1:0] req_inputs;
    logic [NUM_INPUTS*DATA_W-1:0]         tree_inputs;
    logic                                 tree_start;
    logic [DATA_W-1:0]                    tree_result;
    logic                                 res_valid;
    logic                                 res_ready;
    logic [DATA_W-1:0]                    res_data;
    logic [ID_W-1:0]                      res_id;
    logic                                 flush;

    modport slave (
        input  req_valid, req_inputs, tree_result, res_ready, flush,
        output req_ready, tree_inputs, tree_start, res_valid, res_data, res_id
    );

    modport master (
        output req_valid, req_inputs, tree_result, res_ready, flush,
        input  req_ready, tree_inputs, tree_start, res_valid, res_data, res_id
    );

endinterface

// File: rtl/min_max_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester after ptr wins; gnt_idx falls back to ptr when idle.
module rr_arbiter
    import min_max_sched_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic found;

    always_comb begin
        found   = 1'b0;
        gnt_idx = ptr;
        gnt     = '0;
        for (int k = 1; k <= N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && req[j] && (j == (int'(ptr) + k) % N)) begin
                    found   = 1'b1;
                    gnt_idx = IW'(j);
                    if (en) gnt[j] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/min_max_scheduler.sv
// Shares one pipelined min/max tree among NUM_REQ requesters and tags results with their owner.
// Optional statistics counters are enabled by defining MIN_MAX_SCHED_STATS_EN.
module min_max_scheduler
    import min_max_sched_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int NUM_INPUTS = DEF_NUM_INPUTS,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic                clk,
    input  logic                rst_n,
    min_max_scheduler_if.slave  bus
`ifdef MIN_MAX_SCHED_STATS_EN
    ,
    output logic [31:0]         stat_accepted,
    output logic [31:0]         stat_stall
`endif
);

    localparam int ID_W    = idx_w(NUM_REQ);
    localparam int SLICE_W = NUM_INPUTS * DATA_W;

    logic [LATENCY-1:0] vld_p;
    logic [ID_W-1:0]    id_p [LATENCY];
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic               advance;
    logic               start;
    logic               any_req;

    // A full output stage that is not being drained freezes the whole tree, bubbles included.
    assign advance = ~vld_p[LATENCY-1] | bus.res_ready;
    assign start   = advance & ~bus.flush;
    assign any_req = |bus.req_valid;

    rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
        .req     (bus.req_valid),
        .ptr     (rr_ptr),
        .en      (start),
        .gnt     (grant),
        .gnt_idx (grant_idx)
    );

    always_comb begin
        bus.tree_inputs = bus.req_inputs[SLICE_W-1:0];
        for (int k = 1; k < NUM_REQ; k++) begin
            if (grant_idx == ID_W'(k)) bus.tree_inputs = bus.req_inputs[k*SLICE_W +: SLICE_W];
        end
    end

    assign bus.req_ready  = grant;
    assign bus.tree_start = start;
    assign bus.res_valid  = vld_p[LATENCY-1];
    assign bus.res_id     = id_p[LATENCY-1];
    assign bus.res_data   = bus.tree_result;

    // Shadow pipeline: one valid/owner pair per tree register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p  <= '0;
            rr_ptr <= ID_W'(NUM_REQ - 1);
            for (int k = 0; k < LATENCY; k++) id_p[k] <= '0;
        end else if (bus.flush) begin
            vld_p <= '0;
        end else if (advance) begin
            vld_p[0] <= any_req;
            id_p[0]  <= grant_idx;
            for (int k = 1; k < LATENCY; k++) begin
                vld_p[k] <= vld_p[k-1];
                id_p[k]  <= id_p[k-1];
            end
            if (any_req) rr_ptr <= grant_idx;
        end
    end

`ifdef MIN_MAX_SCHED_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_accepted <= '0;
            stat_stall    <= '0;
        end else begin
            if (|grant) stat_accepted <= sat_inc(stat_accepted);
            if (vld_p[LATENCY-1] & ~bus.res_ready) stat_stall <= sat_inc(stat_stall);
        end
    end
`endif

endmodule

// File: tb/tb_min_max_scheduler.sv
// Directed bench for min_max_scheduler driving a 3-stage min-tree model.
module tb_min_max_scheduler;
    import min_max_sched_pkg::*;

    localparam int NR = 2;
    localparam int NI = 6;
    localparam int DW = 3;
    localparam int SW = NI * DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    min_max_scheduler_if #(.NUM_REQ(NR), .NUM_INPUTS(NI), .DATA_W(DW)) bus ();

`ifdef MIN_MAX_SCHED_STATS_EN
    logic [31:0] stat_accepted;
    logic [31:0] stat_stall;
`endif

    min_max_scheduler #(.NUM_REQ(NR), .NUM_INPUTS(NI), .DATA_W(DW), .LATENCY(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef MIN_MAX_SCHED_STATS_EN
        ,
        .stat_accepted (stat_accepted),
        .stat_stall    (stat_stall)
`endif
    );

    // Min-tree model: three register stages advancing only on tree_start.
    data_t t0, t1, t2;

    function automatic data_t vmin(input logic [SW-1:0] v);
        data_t m;
        m = v[DW-1:0];
        for (int j = 1; j < NI; j++) if (v[j*DW +: DW] < m) m = v[j*DW +: DW];
        return m;
    endfunction

    always @(posedge clk) begin
        if (bus.tree_start) begin
            t0 <= vmin(bus.tree_inputs);
            t1 <= t0;
            t2 <= t1;
        end
    end
    assign bus.tree_result = t2;

    function automatic logic [SW-1:0] pack6(input int a, b, c, d, e, f);
        return {3'(f), 3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        bus.flush     = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        idle();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        idle();
        bus.req_inputs = '0;
        rst_n = 1'b0;
        bus.req_valid = 2'b11;
        #1;
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%0b exp=0", bus.res_valid); end
        checks++; if (bus.res_id !== 1'b0) begin errors++; $display("FAIL reset_res_id got=%0d exp=0", bus.res_id); end
        checks++; if (bus.tree_start !== 1'b1) begin errors++; $display("FAIL reset_tree_start got=%0b exp=1", bus.tree_start); end
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL reset_req_ready_both got=%b exp=01", bus.req_ready); end
        bus.req_valid = 2'b10;
        #1;
        checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL reset_req_ready_r1 got=%b exp=10", bus.req_ready); end
        tick();
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_hold_valid got=%0b exp=0", bus.res_valid); end
        idle();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        apply_reset();
        bus.req_inputs[SW-1:0] = pack6(5, 1, 7, 2, 6, 3);
        bus.req_valid = 2'b01;
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got=%b exp=01", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL single_early1 got=%0b exp=0", bus.res_valid); end
        tick();
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL single_early2 got=%0b exp=0", bus.res_valid); end
        tick();
        checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%0b exp=1", bus.res_valid); end
        checks++; if (bus.res_data !== 3'd1) begin errors++; $display("FAIL single_data got=%0d exp=1", bus.res_data); end
        checks++; if (bus.res_id !== 1'b0) begin errors++; $display("FAIL single_id got=%0d exp=0", bus.res_id); end
        tick();
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%0b exp=0", bus.res_valid); end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp_rdy;
        apply_reset();
        bus.req_inputs = {pack6(6, 7, 7, 6, 7, 7), pack6(2, 3, 4, 5, 6, 7)};
        bus.req_valid  = 2'b11;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (bus.req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant[%0d] got=%b exp=%b", k, bus.req_ready, exp_rdy); end
            if (k >= 3) begin
                checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d] got=%0b exp=1", k, bus.res_valid); end
                checks++; if (bus.res_id !== 1'((k - 3) % 2)) begin errors++; $display("FAIL rr_id[%0d] got=%0d exp=%0d", k, bus.res_id, (k - 3) % 2); end
                checks++; if (bus.res_data !== (((k - 3) % 2 == 1) ? 3'd6 : 3'd2)) begin errors++; $display("FAIL rr_data[%0d] got=%0d", k, bus.res_data); end
            end else begin
                checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rr_fill[%0d] got=%0b exp=0", k, bus.res_valid); end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_backpressure();
        logic [SW-1:0] vecs [3];
        logic [2:0]    exp_d [3];
        vecs[0] = pack6(3, 4, 5, 6, 7, 3); exp_d[0] = 3'd3;
        vecs[1] = pack6(7, 1, 2, 3, 4, 5); exp_d[1] = 3'd1;
        vecs[2] = pack6(5, 6, 7, 7, 6, 5); exp_d[2] = 3'd5;
        apply_reset();
        bus.req_valid = 2'b01;
        for (int k = 0; k < 3; k++) begin
            bus.req_inputs[SW-1:0] = vecs[k];
            tick();
        end
        bus.req_inputs[SW-1:0] = pack6(4, 4, 4, 4, 4, 4);
        bus.res_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (bus.tree_start !== 1'b0) begin errors++; $display("FAIL bp_start[%0d] got=%0b exp=0", k, bus.tree_start); end
            checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=00", k, bus.req_ready); end
            checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got=%0b exp=1", k, bus.res_valid); end
            checks++; if (bus.res_data !== 3'd3) begin errors++; $display("FAIL bp_data[%0d] got=%0d exp=3", k, bus.res_data); end
            checks++; if (bus.res_id !== 1'b0) begin errors++; $display("FAIL bp_id[%0d] got=%0d exp=0", k, bus.res_id); end
            tick();
        end
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL bp_rel_valid[%0d] got=%0b exp=1", k, bus.res_valid); end
            checks++; if (bus.res_data !== exp_d[k]) begin errors++; $display("FAIL bp_rel_data[%0d] got=%0d exp=%0d", k, bus.res_data, exp_d[k]); end
            tick();
        end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got=%0b exp=0", bus.res_valid); end
    endtask

    task automatic test_flush();
        apply_reset();
        bus.req_valid = 2'b01;
        bus.req_inputs[SW-1:0] = pack6(2, 3, 4, 5, 6, 7);
        tick();
        bus.req_inputs[SW-1:0] = pack6(4, 5, 6, 7, 7, 7);
        tick();
        bus.flush = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL flush_ready got=%b exp=00", bus.req_ready); end
        checks++; if (bus.tree_start !== 1'b0) begin errors++; $display("FAIL flush_start got=%0b exp=0", bus.tree_start); end
        tick();
        bus.flush = 1'b0;
        bus.req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL flush_stale[%0d] got=%0b exp=0", k, bus.res_valid); end
            tick();
        end
        bus.req_valid = 2'b10;
        bus.req_inputs[2*SW-1:SW] = pack6(6, 7, 7, 7, 7, 6);
        #1;
        checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL flush_next_ready got=%b exp=10", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL flush_next_valid got=%0b exp=1", bus.res_valid); end
        checks++; if (bus.res_data !== 3'd6) begin errors++; $display("FAIL flush_next_data got=%0d exp=6", bus.res_data); end
        checks++; if (bus.res_id !== 1'b1) begin errors++; $display("FAIL flush_next_id got=%0d exp=1", bus.res_id); end
        tick();
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus.req_valid = 2'b10;
        bus.req_inputs = {pack6(3, 3, 3, 3, 3, 3), pack6(3, 3, 3, 3, 3, 3)};
        tick();
        tick();
        tick();
        #1;
        checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got=%0b exp=1", bus.res_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL areset_drop got=%0b exp=0", bus.res_valid); end
        checks++; if (bus.res_id !== 1'b0) begin errors++; $display("FAIL areset_id got=%0d exp=0", bus.res_id); end
        rst_n = 1'b1;
        bus.req_valid = 2'b11;
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL areset_first got=%b exp=01", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL areset_after got=%0b exp=0", bus.res_valid); end
        idle();
    endtask

`ifdef MIN_MAX_SCHED_STATS_EN
    task automatic test_stats();
        test_backpressure();
        bus.req_valid = 2'b01;
        for (int k = 0; k < 7; k++) tick();
        idle();
        #1;
        checks++; if (stat_accepted !== 32'd10) begin errors++; $display("FAIL stat_accepted got=%0d exp=10", stat_accepted); end
        checks++; if (stat_stall !== 32'd4) begin errors++; $display("FAIL stat_stall got=%0d exp=4", stat_stall); end
    endtask
`endif

    initial begin
        idle();
        bus.req_inputs = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_async_reset();
`ifdef MIN_MAX_SCHED_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/min_max_scheduler.md
# min_max_scheduler

Request scheduler for the pipelined min/max comparator tree used in the fuzzy inference datapath. It shares one tree instance between NUM_REQ requesters using round-robin arbitration and drives the tree's `start` (advance) enable. It tracks which requester owns each in-flight vector and returns results with a valid/ready handshake. When the consumer stalls, it holds the whole tree pipeline.

## Interface
- NUM_REQ, 2: number of requesters (≥1); ID_W = max(1, $clog2(NUM_REQ)).
- NUM_INPUTS, 6: operands per vector.
- DATA_W, 3: operand/result width.
- LATENCY, 3: number of register stages in the attached tree (≥1).
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  requester i offers a vector.
- req_ready  out  NUM_REQ  requester i's vector is accepted this cycle.
- req_inputs  in  NUM_REQ*NUM_INPUTS*DATA_W  packed vectors; requester i occupies slice i.
- tree_inputs  out  NUM_INPUTS*DATA_W  vector driven into the tree.
- tree_start  out  1  tree pipeline advance enable.
- tree_result  in  DATA_W  output of the tree's last register.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  DATA_W  result (= tree_result).
- res_id  out  ID_W  index of the requester that owns res_data.
- flush  in  1  synchronous discard of all in-flight vectors.

## Operation
- The shadow pipeline consists of vld[LATENCY] and id[LATENCY], mirroring the tree stages.
- advance = ~vld[LATENCY-1] | res_ready.
- tree_start = advance & ~flush.
- Arbitration:
  - grant = first i with req_valid[i], searching from rr_ptr+1 (mod NUM_REQ).
  - req_ready[i] = advance & ~flush & (grant==i).
  - At most one bit of req_ready is set.
- tree_inputs = req_inputs slice of grant. With no request, it is the slice of rr_ptr (don't-care bubble).
- On advance (and no flush):
  - vld[0] <= any req_valid.
  - id[0] <= grant.
  - vld[k] <= vld[k-1] and id[k] <= id[k-1].
  - rr_ptr <= grant only if a request was accepted.
- When advance=0: vld, id and rr_ptr hold. tree_start=0, so the tree holds too.
- res_valid = vld[LATENCY-1]; res_id = id[LATENCY-1].
- flush:
  - Next edge clears all vld bits.
  - id and rr_ptr hold.
  - No request is accepted in the flush cycle.
  - A result presented in the flush cycle is still transferred if res_ready=1.
- Bubbles propagate freely. A stalled output blocks every stage, including bubbles, so no internal compaction occurs.
- Starvation-free: a continuously valid requester is granted within NUM_REQ accepted transfers.

## Timing
- Reset (reset=0): vld=0, id=0, rr_ptr=NUM_REQ-1 (requester 0 has first priority).
- Outputs during and after reset: res_valid=0, res_id=0, tree_start=1, req_ready follows req_valid.
- Latency: a vector accepted at edge t yields res_valid=1 after edge t+LATENCY-1, provided there is no stall.
- Throughput is one vector per cycle with res_ready held high.
- res_valid=1 & res_ready=0 holds the following stable until the handshake completes: res_data, res_id, tree_start=0, req_ready=0.
- Simultaneous result handshake and new accept is legal; both occur in the same cycle.
- flush and reset mid-operation: in-flight results are lost; no spurious res_valid afterwards.
- Reset deassertion is synchronised externally; the block samples nothing combinationally from reset except register clears.

## Configuration
- MIN_MAX_SCHED_STATS_EN defined:
  - Adds stat_accepted (out, 32): saturating count of accepted requests.
  - Adds stat_stall (out, 32): saturating count of cycles with res_valid & ~res_ready.
  - Both counters reset to 0 and are unaffected by flush.
- Not defined: the ports and counters are absent, and the remaining behaviour is identical.

## Structure
- Package min_max_sched_pkg:
  - default constants (DATA_W=3, NUM_INPUTS=6, LATENCY=3);
  - typedef data_t (logic [DATA_W-1:0]);
  - function idx_w(n) returning max(1, $clog2(n)).
- Sub-module rr_arbiter:
  - parameter N;
  - inputs req, ptr, en;
  - outputs one-hot gnt and binary gnt_idx.
- The comparator tree is instantiated by the parent, not inside this block.

## Test plan
- Bench attaches a min-tree model with LATENCY=3. Single request: req0 vector {5,1,7,2,6,3} accepted at cycle 1 -> res_valid at cycle 3, res_data=1, res_id=0.
- Both requesters valid continuously, res_ready=1:
  - grants alternate 0,1,0,1;
  - res_id alternates the same way;
  - one result per cycle after fill.
- Backpressure: three vectors in flight, res_ready=0 for 4 cycles:
  - tree_start=0 and req_ready=0 throughout;
  - res_data/res_id stable;
  - on release, all three results are delivered in order with no loss or duplicate.
- flush asserted with 2 vectors in flight -> res_valid=0 from the next cycle; no stale result appears afterwards; the next request completes normally.
- Asynchronous reset asserted mid-pipeline (no clock edge) -> res_valid drops immediately; after release, req0 wins first.
- With MIN_MAX_SCHED_STATS_EN: 10 accepts and 4 stall cycles -> stat_accepted=10, stat_stall=4; a counter preloaded near saturation stays at 0xFFFFFFFF.
